// File: rtl/divisor_prog.sv
// divisor_prog: multi-channel programmable clock divider with glitch-free ratio update
module divisor_prog #(
    parameter int N_CH = 4,
    parameter int W = 16,
    parameter int DEF_DIV = 2,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] en_i,
    input  logic            sync_i,
    input  logic            cfg_we_i,
    input  logic [CW-1:0]   cfg_ch_i,
    input  logic [W-1:0]    cfg_div_i,
    output logic [N_CH-1:0] clk_div_o,
    output logic [N_CH-1:0] tick_o,
    output logic [N_CH-1:0] pend_o
);
    logic [N_CH-1:0]         run_q, run_d, pend_q, pend_d, bnd, wr;
    logic [N_CH-1:0][W-1:0]  cnt_q, cnt_d, act_q, act_d, sh_q, sh_d;

    // Next state: shadow takes writes, pending ratio moves to active only at a period boundary
    always_comb begin
        run_d = en_i;
        bnd = '0;
        wr = '0;
        cnt_d = cnt_q;
        act_d = act_q;
        sh_d = sh_q;
        pend_d = pend_q;
        for (int c = 0; c < N_CH; c++) begin
            wr[c] = cfg_we_i && (cfg_ch_i == CW'(c));
            bnd[c] = !run_q[c] || (act_q[c] == '0) || sync_i || (cnt_q[c] == act_q[c] - W'(1));
            cnt_d[c] = bnd[c] ? '0 : cnt_q[c] + W'(1);
            act_d[c] = (bnd[c] && pend_q[c]) ? sh_q[c] : act_q[c];
            sh_d[c] = wr[c] ? cfg_div_i : sh_q[c];
            pend_d[c] = wr[c] || (pend_q[c] && !bnd[c]);
        end
    end

    // State registers; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
            pend_q <= '0;
            cnt_q <= '0;
            act_q <= {N_CH{W'(DEF_DIV)}};
            sh_q <= {N_CH{W'(DEF_DIV)}};
        end else begin
            run_q <= run_d;
            pend_q <= pend_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
            sh_q <= sh_d;
        end
    end

    // Outputs decoded purely from flops: high for the first ceil(R/2) counts, tick at count 0
    always_comb begin
        tick_o = '0;
        clk_div_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            tick_o[c] = run_q[c] && (act_q[c] != '0) && (cnt_q[c] == '0);
            clk_div_o[c] = run_q[c] && (act_q[c] != '0) &&
                           ({1'b0, cnt_q[c]} < (({1'b0, act_q[c]} + (W+1)'(1)) >> 1));
        end
    end

    assign pend_o = pend_q;
endmodule

// File: tb/tb_divisor_prog.sv
// tb_divisor_prog: table, directed and randomized checks of divisor_prog against a rule-level model
module tb_divisor_prog;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        we;
    logic [1:0]  cch;
    logic [15:0] cdiv;
    logic [3:0]  clk_div_o, tick_o, pend_o;
    int checks = 0;
    int errors = 0;

    int m_run[4], m_cnt[4], m_act[4], m_sh[4], m_pend[4];

    typedef struct {
        logic [3:0]  en;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic [3:0]  tick, clk, pend;
    } vec_t;
    vec_t tbl[11];

    divisor_prog #(.N_CH(4), .W(16), .DEF_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .sync_i(sync), .cfg_we_i(we),
        .cfg_ch_i(cch), .cfg_div_i(cdiv), .clk_div_o(clk_div_o), .tick_o(tick_o), .pend_o(pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_run[c] = 0; m_cnt[c] = 0; m_act[c] = 2; m_sh[c] = 2; m_pend[c] = 0;
        end
    endtask

    // One clock of the channel rules: boundary restarts the count and applies a pending ratio,
    // then a write lands in the shadow and marks it pending.
    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            if (m_run[c] == 0 || m_act[c] == 0 || sync || m_cnt[c] == m_act[c] - 1) begin
                m_cnt[c] = 0;
                if (m_pend[c] != 0) begin
                    m_act[c] = m_sh[c];
                    m_pend[c] = 0;
                end
            end else
                m_cnt[c] = m_cnt[c] + 1;
            m_run[c] = en[c] ? 1 : 0;
            if (we && cch == c) begin
                m_sh[c] = cdiv;
                m_pend[c] = 1;
            end
        end
    endtask

    function automatic logic [3:0] m_tick();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_run[c] != 0 && m_act[c] != 0 && m_cnt[c] == 0;
        return v;
    endfunction

    function automatic logic [3:0] m_clk();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_run[c] != 0 && m_act[c] != 0 && m_cnt[c] < (m_act[c] + 1) / 2;
        return v;
    endfunction

    function automatic logic [3:0] m_pnd();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_pend[c] != 0;
        return v;
    endfunction

    task automatic step(input logic [3:0] e, input logic s, input logic w,
                        input logic [1:0] ch, input logic [15:0] d);
        en = e; sync = s; we = w; cch = ch; cdiv = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_tick", {28'd0, tick_o}, {28'd0, m_tick()});
        chk("model_clk", {28'd0, clk_div_o}, {28'd0, m_clk()});
        chk("model_pend", {28'd0, pend_o}, {28'd0, m_pnd()});
    endtask

    task automatic run(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 2'd0, 16'd0);
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b1, 2'd1, 16'd5, 4'b0001, 4'b0001, 4'b0010};
        tbl[5]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0011, 4'b0000};
        tbl[7]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0001, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0011, 4'b0000};

        rst_n = 1'b0; en = '0; sync = 0; we = 0; cch = '0; cdiv = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tick", {28'd0, tick_o}, 32'd0);
        chk("rst_clk", {28'd0, clk_div_o}, 32'd0);
        chk("rst_pend", {28'd0, pend_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tick", {28'd0, tick_o}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, 1'b0, tbl[i].we, tbl[i].ch, tbl[i].div);
            chk($sformatf("tbl%0d_tick", i), {28'd0, tick_o}, {28'd0, tbl[i].tick});
            chk($sformatf("tbl%0d_clk", i), {28'd0, clk_div_o}, {28'd0, tbl[i].clk});
            chk($sformatf("tbl%0d_pend", i), {28'd0, pend_o}, {28'd0, tbl[i].pend});
        end

        step(4'b0011, 1'b0, 1'b1, 2'd2, 16'd1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
            chk("r1_tick", {31'd0, tick_o[2]}, 32'd1);
            chk("r1_clk", {31'd0, clk_div_o[2]}, 32'd1);
        end
        step(4'b0111, 1'b0, 1'b1, 2'd2, 16'd0);
        chk("r0_before_apply", {31'd0, clk_div_o[2]}, 32'd1);
        step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
        chk("r0_tick", {31'd0, tick_o[2]}, 32'd0);
        chk("r0_clk", {31'd0, clk_div_o[2]}, 32'd0);
        step(4'b0111, 1'b0, 1'b1, 2'd2, 16'd3);
        chk("r3_pending_clk", {31'd0, clk_div_o[2]}, 32'd0);
        step(4'b0111, 1'b0, 1'b0, 2'd0, 16'd0);
        chk("r3_first_tick", {31'd0, tick_o[2]}, 32'd1);
        run(2, 4'b0111);
        chk("r3_cnt2_clk", {31'd0, clk_div_o[2]}, 32'd0);
        run(1, 4'b0111);
        chk("r3_second_tick", {31'd0, tick_o[2]}, 32'd1);

        step(4'b0111, 1'b0, 1'b1, 2'd0, 16'd4);
        step(4'b0111, 1'b0, 1'b1, 2'd1, 16'd6);
        run(10 + $urandom_range(0, 7), 4'b0111);
        step(4'b0111, 1'b1, 1'b0, 2'd0, 16'd0);
        chk("sync_tick", {30'd0, tick_o[1:0]}, 32'd3);
        run(11, 4'b0111);
        chk("sync_pre12", {30'd0, tick_o[1:0]}, 32'd0);
        run(1, 4'b0111);
        chk("sync_12", {30'd0, tick_o[1:0]}, 32'd3);

        step(4'b1111, 1'b0, 1'b1, 2'd3, 16'd4);
        run(8, 4'b1111);
        step(4'b1111, 1'b1, 1'b0, 2'd0, 16'd0);
        step(4'b1111, 1'b0, 1'b1, 2'd3, 16'd2);
        run(2, 4'b1111);
        step(4'b1111, 1'b0, 1'b1, 2'd3, 16'd7);
        chk("coll_pend", {31'd0, pend_o[3]}, 32'd1);
        chk("coll_tick", {31'd0, tick_o[3]}, 32'd1);
        run(1, 4'b1111);
        chk("coll_pend_hold", {31'd0, pend_o[3]}, 32'd1);
        run(1, 4'b1111);
        chk("coll_applied", {31'd0, pend_o[3]}, 32'd0);
        chk("coll_tick2", {31'd0, tick_o[3]}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] e;
            e = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : en;
            step(e, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 9)));
        end

        step(4'b1111, 1'b0, 1'b1, 2'd0, 16'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", {28'd0, tick_o}, 32'd0);
        chk("arst_clk", {28'd0, clk_div_o}, 32'd0);
        chk("arst_pend", {28'd0, pend_o}, 32'd0);
        model_reset();
        en = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b0, 1'b0, 2'd0, 16'd0);
            chk("post_tick", {28'd0, tick_o}, (i % 2 == 0) ? 32'hF : 32'h0);
            chk("post_clk", {28'd0, clk_div_o}, (i % 2 == 0) ? 32'hF : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
